// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: opcodes, status bit positions, datapath width.
// Shifter support is controlled by the ALU_SHIFT_EN macro in the top level.
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [3:0] OP_PASS = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;

    localparam int ST_Z   = 0;
    localparam int ST_N   = 1;
    localparam int ST_C   = 2;
    localparam int ST_V   = 3;
    localparam int ST_ILL = 4;

    localparam logic [4:0] STATUS_RST = 5'b00001;

endpackage

// File: rtl/alu_adder.sv
// 32-bit adder with carry-in; overflow is judged on the operands actually presented,
// so a caller that pre-inverts b for subtraction gets the subtraction overflow.
module alu_adder
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a_i,
    input  logic [ALU_W-1:0] b_i,
    input  logic             cin_i,
    output logic [ALU_W-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    logic [ALU_W:0] full_sum;

    assign full_sum = {1'b0, a_i} + {1'b0, b_i} + {{ALU_W{1'b0}}, cin_i};
    assign sum_o    = full_sum[ALU_W-1:0];
    assign cout_o   = full_sum[ALU_W];
    assign ovf_o    = (a_i[ALU_W-1] == b_i[ALU_W-1]) && (sum_o[ALU_W-1] != a_i[ALU_W-1]);

endmodule

// File: rtl/alu.sv
// Registered 32-bit ALU: opcode mux, flag generation and output registers.
// Define ALU_SHIFT_EN to build the SLL/SRL/SRA shifter; otherwise those opcodes are illegal.
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ALU_W-1:0] in1,
    input  logic [ALU_W-1:0] in2,
    input  logic [3:0]       op,
    output logic [ALU_W-1:0] result,
    output logic [4:0]       status
);

    logic [ALU_W-1:0] result_d, result_q;
    logic [4:0]       status_d, status_q;

    logic             sub_sel;
    logic [ALU_W-1:0] add_b;
    logic [ALU_W-1:0] add_sum;
    logic             add_cout;
    logic             add_ovf;

    // SUB, SLT and SLTU all reuse the adder as in1 + ~in2 + 1
    assign sub_sel = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    assign add_b   = sub_sel ? ~in2 : in2;

    alu_adder u_adder (
        .a_i    (in1),
        .b_i    (add_b),
        .cin_i  (sub_sel),
        .sum_o  (add_sum),
        .cout_o (add_cout),
        .ovf_o  (add_ovf)
    );

    always_comb begin
        logic c_flag;
        logic v_flag;
        logic ill_flag;
        result_d = '0;
        c_flag   = 1'b0;
        v_flag   = 1'b0;
        ill_flag = 1'b0;
        case (op)
            OP_PASS: result_d = in1;
            OP_AND:  result_d = in1 & in2;
            OP_OR:   result_d = in1 | in2;
            OP_XOR:  result_d = in1 ^ in2;
            OP_NOR:  result_d = ~(in1 | in2);
            OP_ADD, OP_SUB: begin
                result_d = add_sum;
                c_flag   = add_cout;
                v_flag   = add_ovf;
            end
            // signed less-than is the sign of the true difference: N xor V
            OP_SLT:  result_d = {{(ALU_W-1){1'b0}}, add_sum[ALU_W-1] ^ add_ovf};
            OP_SLTU: result_d = {{(ALU_W-1){1'b0}}, ~add_cout};
`ifdef ALU_SHIFT_EN
            OP_SLL:  result_d = in1 << in2[4:0];
            OP_SRL:  result_d = in1 >> in2[4:0];
            OP_SRA:  result_d = $unsigned($signed(in1) >>> in2[4:0]);
`endif
            default: ill_flag = 1'b1;
        endcase
        status_d         = '0;
        status_d[ST_Z]   = (result_d == '0);
        status_d[ST_N]   = result_d[ALU_W-1];
        status_d[ST_C]   = c_flag;
        status_d[ST_V]   = v_flag;
        status_d[ST_ILL] = ill_flag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            status_q <= STATUS_RST;
        end else begin
            result_q <= result_d;
            status_q <= status_d;
        end
    end

    assign result = result_q;
    assign status = status_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver pushes model predictions, monitor pops one per clock.
// Honours ALU_SHIFT_EN the same way as the design build.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  op;
    logic [31:0] result;
    logic [4:0]  status;

    typedef struct {
        logic [31:0] r;
        logic [4:0]  s;
        logic [3:0]  op;
        logic        rst;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared = 0;
    int   n_failed   = 0;
    int   txn        = 0;
    bit   stim_done  = 0;

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .in1    (in1),
        .in2    (in2),
        .op     (op),
        .result (result),
        .status (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain arithmetic on wide signed/unsigned values.
    function automatic logic [36:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        c, v, ill;
        longint      sa, sb, st;
        r   = 32'd0;
        c   = 1'b0;
        v   = 1'b0;
        ill = 1'b0;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        case (o)
            4'd0:  r = a;
            4'd1:  r = a & b;
            4'd2:  r = a | b;
            4'd3:  r = a ^ b;
            4'd4: begin
                r  = a + b;
                c  = (longint'(a) + longint'(b)) > 64'sd4294967295;
                st = sa + sb;
                v  = (st != longint'($signed(r)));
            end
            4'd5: begin
                r  = a - b;
                c  = (a >= b);
                st = sa - sb;
                v  = (st != longint'($signed(r)));
            end
`ifdef ALU_SHIFT_EN
            4'd6:  r = a << b[4:0];
            4'd7:  r = a >> b[4:0];
            4'd8:  r = $unsigned($signed(a) >>> b[4:0]);
`endif
            4'd9:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd10: r = (a < b) ? 32'd1 : 32'd0;
            4'd11: r = ~(a | b);
            default: ill = 1'b1;
        endcase
        return {ill, v, c, r[31], (r == 32'd0), r};
    endfunction

    task automatic drive(input logic r, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [36:0] m;
        @(negedge clk);
        rst = r;
        op  = o;
        in1 = a;
        in2 = b;
        m   = model(o, a, b);
        e.op  = o;
        e.rst = r;
        if (r) begin
            e.r = 32'd0;
            e.s = 5'b00001;
        end else begin
            e.r = m[31:0];
            e.s = m[36:32];
        end
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_0001;
            5: return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    // Monitor: the design produces one result per cycle, so every edge retires one entry.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            txn++;
            n_compared++;
            if (result !== e.r || status !== e.s) begin
                n_failed++;
                $display("FAIL txn%0d op=%b rst=%0b: got result=%h status=%b, want result=%h status=%b",
                         txn, e.op, e.rst, result, status, e.r, e.s);
            end else begin
                $display("ok   txn%0d op=%b rst=%0b result=%h status=%b", txn, e.op, e.rst, result, status);
            end
        end
    end

    initial begin
        rst = 1'b1;
        op  = 4'b0100;
        in1 = 32'd1;
        in2 = 32'd1;

        drive(1'b1, 4'b0100, 32'd1, 32'd1);
        drive(1'b1, 4'b0100, 32'd1, 32'd1);
        drive(1'b0, 4'b0100, 32'd1, 32'd1);

        drive(1'b0, 4'b0001, 32'h5, 32'h6);
        drive(1'b0, 4'b0010, 32'h5, 32'h6);
        drive(1'b0, 4'b0011, 32'h5, 32'h6);
        drive(1'b0, 4'b0100, 32'h770F0F05, 32'h770F0F05);
        drive(1'b0, 4'b0100, 32'hFF0F0F05, 32'hFF0F0F05);
        drive(1'b0, 4'b0101, 32'd5, 32'd5);
        drive(1'b0, 4'b0101, 32'h80000000, 32'd1);
        drive(1'b0, 4'b1001, 32'hFFFFFFFF, 32'd1);
        drive(1'b0, 4'b1010, 32'hFFFFFFFF, 32'd1);
        drive(1'b0, 4'b1000, 32'h80000000, 32'd31);
        drive(1'b0, 4'b0110, 32'd1, 32'd31);
        drive(1'b0, 4'b0111, 32'hF000000F, 32'd0);
        drive(1'b0, 4'b0111, 32'hF000000F, 32'h24);
        drive(1'b0, 4'b1111, 32'h12345678, 32'h9ABCDEF0);
        drive(1'b0, 4'b0000, 32'h12345678, 32'd0);
        drive(1'b0, 4'b1011, 32'h0F0F0000, 32'h00F0F000);
        drive(1'b1, 4'b0100, 32'hFFFFFFFF, 32'd1);
        drive(1'b0, 4'b0000, 32'hCAFEF00D, 32'd0);

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)), rand_opnd(), rand_opnd());
        end

        stim_done = 1'b1;
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_failed++;
            $display("FAIL drain: %0d outputs outstanding, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
